// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side streamer.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int STAT_W     = 16;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus valid/ready output stream, seen from the streamer (master) or its environment (slave).
interface fifo_rd_streamer_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    output fifo_rd_en, m_valid, m_data, m_last,
    input  fifo_dout, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, m_last,
    output fifo_dout, fifo_empty, m_ready
  );

endinterface

// File: rtl/fifo_rd_streamer_skid_buf2.sv
// Two-entry FIFO-ordered output buffer; head is forced to zero while empty.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head,
  output logic              head_vld
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_vld = (occ != 2'd0);
  assign head     = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a synchronous FIFO onto a valid/ready stream with burst marking.
// Optional FIFO_RD_STATS_EN adds saturating stat_words / stat_stall counters.
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fifo_rd_streamer_if.master  bus,
  output logic                busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_words,
  output logic [STAT_W-1:0]   stat_stall
`endif
);

  localparam int               BCNT_W   = cnt_w(BURST_LEN);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BURST_LEN - 1);

  state_e              state;
  logic                rd_en_p0;
  logic                vld_p1;
  logic [1:0]          occ;
  logic [DATA_W-1:0]   head;
  logic                head_vld;
  logic                pop;
  logic [2:0]          credit_use;
  logic [BCNT_W-1:0]   bcnt;

  // Stage p0: issue a read only if its word is guaranteed a buffer slot.
  assign pop        = head_vld && bus.m_ready;
  assign credit_use = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en_p0   = (state == ST_RUN) && enable && !bus.fifo_empty
                      && (credit_use < 3'd2);

  assign bus.fifo_rd_en = rd_en_p0;
  assign bus.m_valid    = head_vld;
  assign bus.m_data     = head;
  assign bus.m_last     = head_vld && (bcnt == BCNT_MAX);

  // Stage p1: FIFO data is on fifo_dout; write it into the buffer.
  skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (head),
    .head_vld  (head_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      bcnt   <= '0;
    end else begin
      vld_p1 <= rd_en_p0;
      if (pop) bcnt <= (bcnt == BCNT_MAX) ? '0 : bcnt + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable) begin
            state <= ST_RUN;
          end else if (!vld_p1 && (occ == 2'd0)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (pop) stat_words <= sat_inc(stat_words);
      if ((state == ST_RUN) && bus.fifo_empty) stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule
